// File: rtl/cdt_pack_sequencer.sv
// Purpose : sequences the CDT packing datapath of one crate, emitting one framed
//           packet (header, three source segments, trailer, crate ID) per trigger.
// Latency : trig high in cycle t with the queue empty and FSM idle -> pend_cnt=1 at t+1,
//           HDR state at t+2, header word on pk_out at t+3.
// Backpressure: none from the link; triggers queue up to PEND_DEPTH deep and any
//           further trigger while the queue is full is dropped and counted.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   trig            trigger request, one request per high cycle
//   crate_id[4:0]   crate identifier, latched in the HDR state
//   src_data[47:0]  source words {src2, src1, src0}
//   src_rd[2:0]     one-hot source read strobe (combinational from state)
//   pk_out[15:0]    registered frame word, IDLE_WORD when not valid
//   pk_valid/sof/eof  word qualifiers
//   busy            FSM not in IDLE
//   pend_cnt[2:0]   queued triggers
//   drop_cnt[15:0]  triggers dropped on a full queue (saturating)
//
// Build option: define CDT_PACK_CHKSUM_EN to append an XOR checksum word (CHK state)
// after the crate-ID word; eof then moves to the checksum word.

module cdt_pack_sequencer #(
    parameter int unsigned SEG_LEN    = 16,
    parameter int unsigned PEND_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [15:0] HDR_WORD   = 16'hAAAA,
    parameter logic [15:0] TRL_WORD   = 16'h5555,
    parameter logic [15:0] IDLE_WORD  = 16'd999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    input  logic [4:0]  crate_id,
    input  logic [47:0] src_data,
    output logic [2:0]  src_rd,
    output logic [15:0] pk_out,
    output logic        pk_valid,
    output logic        pk_sof,
    output logic        pk_eof,
    output logic        busy,
    output logic [2:0]  pend_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0] SEG_LAST = 8'(SEG_LEN - 1);
    // GAP_LAST is only consulted when the GAP state is reachable (GAP_CYCLES != 0).
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic [2:0] PEND_MAX = 3'(PEND_DEPTH);
    localparam bit         GAP_EN   = (GAP_CYCLES != 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_SEG0,
        S_SEG1,
        S_SEG2,
        S_TRL,
        S_CID,
`ifdef CDT_PACK_CHKSUM_EN
        S_CHK,
`endif
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;          // word counter in SEGk, cycle counter in GAP
    logic [2:0]  pend_q, pend_d;
    logic [15:0] drop_q, drop_d;
    logic [4:0]  cid_q, cid_d;
    logic [15:0] pk_out_q, pk_out_d;
    logic        pk_valid_q, pk_valid_d;
    logic        pk_sof_q, pk_sof_d;
    logic        pk_eof_q, pk_eof_d;
    logic        deq;
    logic        frame_end;
    logic        gap_end;
`ifdef CDT_PACK_CHKSUM_EN
    logic [15:0] chk_q, chk_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        deq       = 1'b0;
        frame_end = 1'b0;
        gap_end   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start decision is shared with the end-of-gap path below
            end
            S_HDR: begin
                state_d = S_SEG0;
                cnt_d   = 8'd0;
            end
            S_SEG0: begin
                if (cnt_q == SEG_LAST) begin
                    state_d = S_SEG1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SEG1: begin
                if (cnt_q == SEG_LAST) begin
                    state_d = S_SEG2;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SEG2: begin
                if (cnt_q == SEG_LAST) begin
                    state_d = S_TRL;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_TRL: begin
                state_d = S_CID;
            end
`ifdef CDT_PACK_CHKSUM_EN
            S_CID: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                frame_end = 1'b1;
            end
`else
            S_CID: begin
                frame_end = 1'b1;
            end
`endif
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    gap_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // With a zero-length gap the last frame word hands straight over to
        // the start decision, so back-to-back frames have no idle word.
        if (frame_end && GAP_EN) begin
            state_d = S_GAP;
            cnt_d   = 8'd0;
        end else if (frame_end || gap_end || (state_q == S_IDLE)) begin
            cnt_d = 8'd0;
            if (pend_q != 3'd0) begin
                state_d = S_HDR;
                deq     = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger queue accounting
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        drop_d = drop_q;
        if (trig && !deq) begin
            if (pend_q < PEND_MAX) begin
                pend_d = pend_q + 3'd1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (!trig && deq) begin
            pend_d = pend_q - 3'd1;
        end
        // trig together with a dequeue leaves the count unchanged
    end

    // ------------------------------------------------------------------
    // Read strobes and next output word
    // ------------------------------------------------------------------
    always_comb begin
        src_rd     = 3'b000;
        pk_out_d   = IDLE_WORD;
        pk_valid_d = 1'b0;
        pk_sof_d   = 1'b0;
        pk_eof_d   = 1'b0;
        cid_d      = cid_q;
`ifdef CDT_PACK_CHKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            S_HDR: begin
                pk_out_d   = HDR_WORD;
                pk_valid_d = 1'b1;
                pk_sof_d   = 1'b1;
                cid_d      = crate_id;
`ifdef CDT_PACK_CHKSUM_EN
                chk_d      = 16'd0;
`endif
            end
            S_SEG0: begin
                src_rd     = 3'b001;
                pk_out_d   = src_data[15:0];
                pk_valid_d = 1'b1;
`ifdef CDT_PACK_CHKSUM_EN
                chk_d      = chk_q ^ src_data[15:0];
`endif
            end
            S_SEG1: begin
                src_rd     = 3'b010;
                pk_out_d   = src_data[31:16];
                pk_valid_d = 1'b1;
`ifdef CDT_PACK_CHKSUM_EN
                chk_d      = chk_q ^ src_data[31:16];
`endif
            end
            S_SEG2: begin
                src_rd     = 3'b100;
                pk_out_d   = src_data[47:32];
                pk_valid_d = 1'b1;
`ifdef CDT_PACK_CHKSUM_EN
                chk_d      = chk_q ^ src_data[47:32];
`endif
            end
            S_TRL: begin
                pk_out_d   = TRL_WORD;
                pk_valid_d = 1'b1;
            end
            S_CID: begin
                pk_out_d   = {11'b0, cid_q};
                pk_valid_d = 1'b1;
`ifndef CDT_PACK_CHKSUM_EN
                pk_eof_d   = 1'b1;
`endif
            end
`ifdef CDT_PACK_CHKSUM_EN
            S_CHK: begin
                pk_out_d   = chk_q;
                pk_valid_d = 1'b1;
                pk_eof_d   = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            pend_q     <= 3'd0;
            drop_q     <= 16'd0;
            cid_q      <= 5'd0;
            pk_out_q   <= IDLE_WORD;
            pk_valid_q <= 1'b0;
            pk_sof_q   <= 1'b0;
            pk_eof_q   <= 1'b0;
`ifdef CDT_PACK_CHKSUM_EN
            chk_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            cid_q      <= cid_d;
            pk_out_q   <= pk_out_d;
            pk_valid_q <= pk_valid_d;
            pk_sof_q   <= pk_sof_d;
            pk_eof_q   <= pk_eof_d;
`ifdef CDT_PACK_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign pk_out   = pk_out_q;
    assign pk_valid = pk_valid_q;
    assign pk_sof   = pk_sof_q;
    assign pk_eof   = pk_eof_q;
    assign busy     = (state_q != S_IDLE);
    assign pend_cnt = pend_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cdt_pack_sequencer.sv
// Directed bench for cdt_pack_sequencer at default parameters.
// Sources are modelled as per-source word counters that advance on each read strobe;
// word value = {source number + 1, 12-bit index}.

module tb_cdt_pack_sequencer;

    localparam int SEG = 16;
`ifdef CDT_PACK_CHKSUM_EN
    localparam int FLEN = 3 * SEG + 4;
`else
    localparam int FLEN = 3 * SEG + 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic [4:0]  crate_id = 5'd0;
    logic [47:0] src_data;
    logic [2:0]  src_rd;
    logic [15:0] pk_out;
    logic        pk_valid;
    logic        pk_sof;
    logic        pk_eof;
    logic        busy;
    logic [2:0]  pend_cnt;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_frame = 0;
    int last_sof = 0;
    int last_eof = 0;
    bit src_const = 1'b0;
    logic [11:0] idx0, idx1, idx2;

    cdt_pack_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .trig     (trig),
        .crate_id (crate_id),
        .src_data (src_data),
        .src_rd   (src_rd),
        .pk_out   (pk_out),
        .pk_valid (pk_valid),
        .pk_sof   (pk_sof),
        .pk_eof   (pk_eof),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            idx0 <= 12'd0;
            idx1 <= 12'd0;
            idx2 <= 12'd0;
        end else begin
            if (src_rd[0]) idx0 <= idx0 + 12'd1;
            if (src_rd[1]) idx1 <= idx1 + 12'd1;
            if (src_rd[2]) idx2 <= idx2 + 12'd1;
        end
    end

    assign src_data = src_const ? {16'h0001, 16'h0001, 16'h0001}
                                : {4'h3, idx2, 4'h2, idx1, 4'h1, idx0};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        trig = 1'b1;
        step;
        trig = 1'b0;
    endtask

    // Waits for a header then checks every word of one frame. Optionally pulses
    // trig npulse times (every 2 cycles from word p0) and changes crate_id at word chg_at.
    task automatic recv_frame(input logic [4:0] exp_cid, input int chg_at,
                              input logic [4:0] chg_val, input int npulse, input int p0);
        int t;
        int k;
        int j;
        int n;
        int rel;
        logic [15:0] e_out;
        logic [15:0] acc;
        logic [2:0]  e_rd;
        t = 0;
        while (pk_sof !== 1'b1 && t < 300) begin
            step;
            t++;
        end
        total++;
        if (pk_sof !== 1'b1) begin
            bad++;
            $display("FAIL frame_sof_timeout: pk_sof=%b expected 1", pk_sof);
            return;
        end
        last_sof = cyc;
        acc = 16'd0;
        for (int w = 0; w < FLEN; w++) begin
            if (w == chg_at) crate_id = chg_val;
            rel = w - p0;
            trig = (npulse > 0) && (rel >= 0) && (rel % 2 == 0) && (rel / 2 < npulse);
            if (w == 0) begin
                e_out = 16'hAAAA;
            end else if (w <= 3 * SEG) begin
                k = (w - 1) / SEG;
                j = (w - 1) % SEG;
                e_out = src_const ? 16'h0001
                                  : 16'(((k + 1) << 12) | ((exp_frame * SEG + j) & 12'hFFF));
                acc = acc ^ e_out;
            end else if (w == 3 * SEG + 1) begin
                e_out = 16'h5555;
            end else if (w == 3 * SEG + 2) begin
                e_out = {11'b0, exp_cid};
            end else begin
                e_out = acc;
            end
            total++;
            if ({pk_valid, pk_sof, pk_eof, pk_out} !== {1'b1, (w == 0), (w == FLEN - 1), e_out}) begin
                bad++;
                $display("FAIL frame%0d_word%0d: valid/sof/eof/data=%b/%b/%b/%h expected 1/%b/%b/%h",
                         exp_frame, w, pk_valid, pk_sof, pk_eof, pk_out,
                         (w == 0), (w == FLEN - 1), e_out);
            end
            n = w + 1;
            if (n >= 1 && n <= SEG) e_rd = 3'b001;
            else if (n > SEG && n <= 2 * SEG) e_rd = 3'b010;
            else if (n > 2 * SEG && n <= 3 * SEG) e_rd = 3'b100;
            else e_rd = 3'b000;
            total++;
            if (src_rd !== e_rd) begin
                bad++;
                $display("FAIL frame%0d_src_rd_w%0d: got %b expected %b", exp_frame, w, src_rd, e_rd);
            end
            if (w != FLEN - 1) step;
        end
        trig = 1'b0;
        last_eof = cyc;
        exp_frame++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        total++;
        if (pk_out !== 16'd999) begin
            bad++; $display("FAIL reset_pk_out: got %h expected %h", pk_out, 16'd999);
        end
        total++;
        if ({pk_valid, pk_sof, pk_eof} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b expected 000", {pk_valid, pk_sof, pk_eof});
        end
        total++;
        if (src_rd !== 3'b000) begin
            bad++; $display("FAIL reset_src_rd: got %b expected 000", src_rd);
        end
        total++;
        if (pend_cnt !== 3'd0 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_counts: pend=%0d drop=%0d expected 0 0", pend_cnt, drop_cnt);
        end
        reset = 1'b0;
        step;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single;
        while (cyc < 10) step;
        total++;
        if (pk_out !== 16'd999 || pk_valid !== 1'b0) begin
            bad++; $display("FAIL single_pre_idle: out=%h valid=%b expected 03e7 0", pk_out, pk_valid);
        end
        crate_id = 5'd13;
        pulse;
        total++;
        if (pend_cnt !== 3'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_t1: pend=%0d busy=%b expected 1 0", pend_cnt, busy);
        end
        step;
        total++;
        if (pend_cnt !== 3'd0 || busy !== 1'b1 || pk_valid !== 1'b0) begin
            bad++; $display("FAIL single_t2: pend=%0d busy=%b valid=%b expected 0 1 0",
                            pend_cnt, busy, pk_valid);
        end
        step;
        total++;
        if (pk_sof !== 1'b1 || pk_out !== 16'hAAAA) begin
            bad++; $display("FAIL single_t3_hdr: sof=%b out=%h expected 1 aaaa", pk_sof, pk_out);
        end
        recv_frame(5'd13, -1, 5'd0, 0, 0);
        step; step; step;
        total++;
        if (pk_out !== 16'd999 || pk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_post_idle: out=%h valid=%b busy=%b expected 03e7 0 0",
                            pk_out, pk_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        int eof1;
        pulse;
        recv_frame(5'd13, -1, 5'd0, 1, 2);
        eof1 = last_eof;
        total++;
        if (pend_cnt !== 3'd1) begin
            bad++; $display("FAIL b2b_pend_peak: got %0d expected 1", pend_cnt);
        end
        recv_frame(5'd13, -1, 5'd0, 0, 0);
        total++;
        if (last_sof - eof1 !== 3) begin
            bad++; $display("FAIL b2b_gap: sof-eof distance %0d expected 3 (2 idle cycles)",
                            last_sof - eof1);
        end
        step; step; step; step;
        total++;
        if (busy !== 1'b0 || pend_cnt !== 3'd0) begin
            bad++; $display("FAIL b2b_drain: busy=%b pend=%0d expected 0 0", busy, pend_cnt);
        end
    endtask

    task automatic test_simultaneous;
        pulse;
        recv_frame(5'd13, -1, 5'd0, 4, 4);
        total++;
        if (pend_cnt !== 3'd4 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL simul_pre: pend=%0d drop=%0d expected 4 0", pend_cnt, drop_cnt);
        end
        step;
        trig = 1'b1;
        step;
        trig = 1'b0;
        total++;
        if (pend_cnt !== 3'd4 || drop_cnt !== 16'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL simul_deq_trig: pend=%0d drop=%0d busy=%b expected 4 0 1",
                            pend_cnt, drop_cnt, busy);
        end
        for (int f = 0; f < 5; f++) recv_frame(5'd13, -1, 5'd0, 0, 0);
        step; step; step; step;
        total++;
        if (busy !== 1'b0 || pend_cnt !== 3'd0) begin
            bad++; $display("FAIL simul_drain: busy=%b pend=%0d expected 0 0", busy, pend_cnt);
        end
    endtask

    task automatic test_overflow;
        int extra;
        pulse;
        recv_frame(5'd13, -1, 5'd0, 6, 4);
        total++;
        if (pend_cnt !== 3'd4 || drop_cnt !== 16'd2) begin
            bad++; $display("FAIL ovf_counts: pend=%0d drop=%0d expected 4 2", pend_cnt, drop_cnt);
        end
        for (int f = 0; f < 4; f++) recv_frame(5'd13, -1, 5'd0, 0, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (pk_sof === 1'b1) extra++;
        end
        total++;
        if (extra !== 0 || busy !== 1'b0 || pend_cnt !== 3'd0 || drop_cnt !== 16'd2) begin
            bad++; $display("FAIL ovf_end: extra_frames=%0d busy=%b pend=%0d drop=%0d expected 0 0 0 2",
                            extra, busy, pend_cnt, drop_cnt);
        end
    endtask

    task automatic test_reset_midframe;
        int t;
        pulse;
        t = 0;
        while (pk_sof !== 1'b1 && t < 50) begin
            step;
            t++;
        end
        total++;
        if (pk_sof !== 1'b1) begin
            bad++; $display("FAIL rst_mid_sof_timeout: pk_sof=%b expected 1", pk_sof);
        end
        trig = 1'b1;
        step;
        step;
        trig = 1'b0;
        for (int i = 2; i < 20; i++) step;
        total++;
        if (pk_valid !== 1'b1 || pend_cnt !== 3'd2) begin
            bad++; $display("FAIL rst_mid_before: valid=%b pend=%0d expected 1 2", pk_valid, pend_cnt);
        end
        reset = 1'b1;
        trig = 1'b1;
        step;
        reset = 1'b0;
        trig = 1'b0;
        exp_frame = 0;
        total++;
        if (pk_valid !== 1'b0 || pk_out !== 16'd999 || pk_eof !== 1'b0) begin
            bad++; $display("FAIL rst_mid_out: valid=%b out=%h eof=%b expected 0 03e7 0",
                            pk_valid, pk_out, pk_eof);
        end
        total++;
        if (src_rd !== 3'b000 || pend_cnt !== 3'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_state: src_rd=%b pend=%0d drop=%0d busy=%b expected 000 0 0 0",
                            src_rd, pend_cnt, drop_cnt, busy);
        end
        step; step;
        total++;
        if (busy !== 1'b0 || pk_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_quiet: busy=%b valid=%b expected 0 0", busy, pk_valid);
        end
        pulse;
        recv_frame(5'd13, -1, 5'd0, 0, 0);
        step; step; step;
        total++;
        if (busy !== 1'b0 || pend_cnt !== 3'd0) begin
            bad++; $display("FAIL rst_mid_after: busy=%b pend=%0d expected 0 0", busy, pend_cnt);
        end
    endtask

    task automatic test_crate_chk;
        src_const = 1'b1;
        crate_id = 5'd3;
        pulse;
        recv_frame(5'd3, 20, 5'd9, 0, 0);
        src_const = 1'b0;
        step; step; step;
        total++;
        if (busy !== 1'b0 || pk_valid !== 1'b0) begin
            bad++; $display("FAIL crate_end: busy=%b valid=%b expected 0 0", busy, pk_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_simultaneous;
        test_overflow;
        test_reset_midframe;
        test_crate_chk;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
